// File: rtl/i2c_pkg.sv
// Shared definitions for the CCD-config I2C register path: FSM states,
// frame widths and the sensor device address.
package i2c_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    localparam logic [6:0]        DEFAULT_SLAVE_ADDR = 7'h5D;
    // Address byte the config initiator sends for a register write (0xBA).
    localparam logic [BYTE_W-1:0] CCD_WRITE_ADDR     = {DEFAULT_SLAVE_ADDR, 1'b0};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WHI,
        ST_WHI_ACK,
        ST_WLO,
        ST_WLO_ACK,
        ST_RHI,
        ST_RHI_ACK,
        ST_RLO,
        ST_RLO_ACK,
        ST_SKIP
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Oversampling front end: synchronizes SCL/SDA and turns their edges into
// single-cycle scl_rise / scl_fall / start / stop pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_level;

    assign scl_level = scl_sync_q[SYNC_STAGES-1];
    assign sda_level = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_level;
        sda_prev_d = sda_level;
    end

    // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise = scl_level & ~scl_prev_q;
    assign scl_fall = ~scl_level & scl_prev_q;
    assign start    = scl_level & scl_prev_q & sda_prev_q & ~sda_level;
    assign stop     = scl_level & scl_prev_q & ~sda_prev_q & sda_level;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register target for the CCD config path: decodes 4-byte write frames
// into reg_wr strobes and serves 16-bit reads from reg_rdata.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic                I2C_SCLK,
    inout  wire                 I2C_SDAT,
    output logic                reg_wr,
    output logic [BYTE_W-1:0]   reg_addr,
    output logic [WORD_W-1:0]   reg_wdata,
    output logic                reg_rd,
    input  logic [WORD_W-1:0]   reg_rdata,
    output logic                busy
);

    logic sda_level, scl_rise, scl_fall, start, stop;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .scl_in    (I2C_SCLK),
        .sda_in    (I2C_SDAT),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (start),
        .stop      (stop)
    );

    i2c_state_e          state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]   rx_q, rx_d;
    logic [BYTE_W-1:0]   wdata_hi_q, wdata_hi_d;
    logic [WORD_W-1:0]   rd_shift_q, rd_shift_d;
    logic                rw_q, rw_d;
    logic                ack_rise_q, ack_rise_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                reg_wr_q, reg_wr_d;
    logic                reg_rd_q, reg_rd_d;
    logic [BYTE_W-1:0]   reg_addr_q, reg_addr_d;
    logic [WORD_W-1:0]   reg_wdata_q, reg_wdata_d;
    logic [BYTE_W-1:0]   rx_byte;

    assign rx_byte = {rx_q, sda_level};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        wdata_hi_d  = wdata_hi_q;
        rd_shift_d  = rd_shift_q;
        rw_d        = rw_q;
        ack_rise_d  = ack_rise_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;

        if (stop) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            bit_cnt_d  = '0;
            ack_rise_d = 1'b0;
        end else if (start) begin
            state_d    = ST_DEV;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = '0;
            ack_rise_d = 1'b0;
        end else begin
            case (state_q)
                ST_DEV, ST_SUB, ST_WHI, ST_WLO: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte[BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ST_DEV: begin
                                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                                        state_d = ST_DEV_ACK;
                                        rw_d    = rx_byte[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = ST_SKIP;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_SUB: begin
                                    reg_addr_d = rx_byte;
                                    state_d    = ST_SUB_ACK;
                                end
                                ST_WHI: begin
                                    wdata_hi_d = rx_byte;
                                    state_d    = ST_WHI_ACK;
                                end
                                default: begin
                                    reg_wr_d    = 1'b1;
                                    reg_wdata_d = {wdata_hi_q, rx_byte};
                                    state_d     = ST_WLO_ACK;
                                end
                            endcase
                        end
                    end
                end

                // First fall after the 8th bit starts our ACK, the next one ends it.
                ST_DEV_ACK, ST_SUB_ACK, ST_WHI_ACK, ST_WLO_ACK: begin
                    if (scl_rise) begin
                        ack_rise_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_rise_d = 1'b0;
                            sda_oe_d   = 1'b0;
                            bit_cnt_d  = '0;
                            case (state_q)
                                ST_DEV_ACK: begin
                                    if (rw_q) begin
                                        state_d    = ST_RHI;
                                        reg_rd_d   = 1'b1;
                                        rd_shift_d = reg_rdata;
                                        sda_oe_d   = ~reg_rdata[WORD_W-1];
                                    end else begin
                                        state_d = ST_SUB;
                                    end
                                end
                                ST_SUB_ACK: state_d = ST_WHI;
                                ST_WHI_ACK: state_d = ST_WLO;
                                default: begin
                                    reg_addr_d = reg_addr_q + 8'd1;
                                    state_d    = ST_WHI;
                                end
                            endcase
                        end
                    end
                end

                ST_RHI, ST_RLO: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_d = (state_q == ST_RHI) ? ST_RHI_ACK : ST_RLO_ACK;
                    end else if (scl_fall) begin
                        rd_shift_d = rd_shift_q << 1;
                        sda_oe_d   = ~rd_shift_q[WORD_W-2];
                    end
                end

                // Shift on the releasing fall too, so bit 15 then holds the low byte's MSB.
                ST_RHI_ACK, ST_RLO_ACK: begin
                    if (scl_rise) begin
                        if (sda_level) begin
                            state_d  = ST_SKIP;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end else begin
                            ack_rise_d = 1'b1;
                            if (state_q == ST_RLO_ACK)
                                reg_addr_d = reg_addr_q + 8'd1;
                        end
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            sda_oe_d   = 1'b0;
                            rd_shift_d = rd_shift_q << 1;
                        end else begin
                            ack_rise_d = 1'b0;
                            bit_cnt_d  = '0;
                            if (state_q == ST_RHI_ACK) begin
                                state_d  = ST_RLO;
                                sda_oe_d = ~rd_shift_q[WORD_W-1];
                            end else begin
                                state_d    = ST_RHI;
                                reg_rd_d   = 1'b1;
                                rd_shift_d = reg_rdata;
                                sda_oe_d   = ~reg_rdata[WORD_W-1];
                            end
                        end
                    end
                end

                ST_SKIP: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            wdata_hi_q  <= '0;
            rd_shift_q  <= '0;
            rw_q        <= 1'b0;
            ack_rise_q  <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            wdata_hi_q  <= wdata_hi_d;
            rd_shift_q  <= rd_shift_d;
            rw_q        <= rw_d;
            ack_rise_q  <= ack_rise_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // Open drain: only ever pull low or float.
    assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C initiator plus a strobe scoreboard.
module tb_i2c_reg_slave;

    localparam int Q = 6;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        scl = 1'b1;
    logic        sda_drv_low = 1'b0;
    wire         sda_bus;
    logic        reg_wr, reg_rd, busy;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;

    assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #10 iCLK = ~iCLK;

    // Register source: 0xC000 at 0x20, otherwise {addr, ~addr}.
    always_comb reg_rdata = (reg_addr == 8'h20) ? 16'hC000 : {reg_addr, ~reg_addr};

    i2c_reg_slave dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda_bus),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    typedef struct {
        logic        is_rd;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } strobe_t;

    strobe_t exp_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic is_rd, input logic [7:0] addr, input logic [15:0] wdata);
        strobe_t e;
        e.is_rd = is_rd;
        e.addr  = addr;
        e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    logic strobe_prev = 1'b0;
    always @(negedge iCLK) begin
        if (reg_wr || reg_rd) begin
            chk_eq("strobe_expected", exp_q.size() > 0, 1);
            chk_eq("strobe_width", strobe_prev, 0);
            chk_eq("strobe_exclusive", reg_wr & reg_rd, 0);
            if (exp_q.size() > 0) begin
                strobe_t e;
                e = exp_q.pop_front();
                chk_eq("strobe_kind", reg_rd, e.is_rd);
                chk_eq("strobe_addr", reg_addr, e.addr);
                if (!e.is_rd)
                    chk_eq("strobe_wdata", reg_wdata, e.wdata);
                $display("txn %s addr=0x%02h wdata=0x%04h", reg_rd ? "rd" : "wr", reg_addr, reg_wdata);
            end
        end
        strobe_prev <= reg_wr | reg_rd;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    // One SCL period; SDA set 1 clk after the previous fall.
    task automatic bit_cycle(input logic drv, input logic val, output logic smp);
        sda_drv_low = drv & ~val;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        smp = sda_bus;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(1);
    endtask

    task automatic i2c_start();
        sda_drv_low = 1'b0;
        scl = 1'b1;
        wait_clk(Q);
        sda_drv_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(1);
    endtask

    task automatic i2c_stop();
        sda_drv_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_drv_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic dummy;
        for (int i = 7; i > 7 - n; i--)
            bit_cycle(1'b1, b[i], dummy);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        bit_cycle(1'b0, 1'b1, ack);
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] b);
        logic dummy;
        for (int i = 7; i >= 0; i--)
            bit_cycle(1'b0, 1'b1, b[i]);
        bit_cycle(1'b1, ~send_ack, dummy);
    endtask

    task automatic write_word_txn(input logic [7:0] sub, input logic [15:0] data);
        logic ack;
        i2c_start();
        write_byte(8'hBA, ack); chk_eq("wr_ack_dev", ack, 0);
        chk_eq("wr_busy", busy, 1);
        write_byte(sub, ack);   chk_eq("wr_ack_sub", ack, 0);
        write_byte(data[15:8], ack); chk_eq("wr_ack_hi", ack, 0);
        push_exp(1'b0, sub, data);
        write_byte(data[7:0], ack);  chk_eq("wr_ack_lo", ack, 0);
        i2c_stop();
        wait_clk(8);
        chk_eq("wr_busy_after_stop", busy, 0);
        chk_eq("wr_sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;

        wait_clk(5);
        chk_eq("rst_reg_wr", reg_wr, 0);
        chk_eq("rst_reg_rd", reg_rd, 0);
        chk_eq("rst_reg_addr", reg_addr, 8'h00);
        chk_eq("rst_reg_wdata", reg_wdata, 16'h0000);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_sda", sda_bus, 1);
        iRST_N = 1'b1;
        wait_clk(5);

        // Single word write
        write_word_txn(8'h09, 16'h1234);
        chk_eq("t1_addr_inc", reg_addr, 8'h0A);

        // Burst write wrapping 0xFF -> 0x00
        i2c_start();
        write_byte(8'hBA, ack); chk_eq("t2_ack_dev", ack, 0);
        write_byte(8'hFF, ack); chk_eq("t2_ack_sub", ack, 0);
        write_byte(8'hAA, ack); chk_eq("t2_ack_b0", ack, 0);
        push_exp(1'b0, 8'hFF, 16'hAAAA);
        write_byte(8'hAA, ack); chk_eq("t2_ack_b1", ack, 0);
        write_byte(8'h55, ack); chk_eq("t2_ack_b2", ack, 0);
        push_exp(1'b0, 8'h00, 16'h5555);
        write_byte(8'h55, ack); chk_eq("t2_ack_b3", ack, 0);
        i2c_stop();
        wait_clk(8);
        chk_eq("t2_addr_wrap", reg_addr, 8'h01);
        chk_eq("t2_sb_drained", exp_q.size(), 0);

        // Foreign address: never ACKed, never busy
        i2c_start();
        write_byte(8'hB8, ack); chk_eq("t3_nack_dev", ack, 1);
        chk_eq("t3_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            write_byte(8'h11 * (i + 1), ack);
            chk_eq("t3_nack_data", ack, 1);
            chk_eq("t3_busy_data", busy, 0);
        end
        i2c_stop();
        wait_clk(8);
        chk_eq("t3_addr_kept", reg_addr, 8'h01);

        // Set sub-address, then read 0xC000 from it
        i2c_start();
        write_byte(8'hBA, ack); chk_eq("t4_ack_dev", ack, 0);
        write_byte(8'h20, ack); chk_eq("t4_ack_sub", ack, 0);
        i2c_stop();
        wait_clk(8);
        chk_eq("t4_addr_set", reg_addr, 8'h20);
        i2c_start();
        push_exp(1'b1, 8'h20, 16'h0000);
        write_byte(8'hBB, ack); chk_eq("t4_ack_rd", ack, 0);
        read_byte(1'b1, rb); chk_eq("t4_rd_hi", rb, 8'hC0);
        read_byte(1'b0, rb); chk_eq("t4_rd_lo", rb, 8'h00);
        wait_clk(6);
        chk_eq("t4_sda_released", sda_bus, 1);
        i2c_stop();
        wait_clk(8);
        chk_eq("t4_addr_after_nack", reg_addr, 8'h20);
        chk_eq("t4_busy", busy, 0);
        chk_eq("t4_sb_drained", exp_q.size(), 0);

        // Partial word (12 data bits) discarded, then a clean write
        i2c_start();
        write_byte(8'hBA, ack); chk_eq("t5_ack_dev", ack, 0);
        write_byte(8'h30, ack); chk_eq("t5_ack_sub", ack, 0);
        write_byte(8'h77, ack); chk_eq("t5_ack_hi", ack, 0);
        send_bits(8'h5A, 4);
        i2c_stop();
        wait_clk(8);
        chk_eq("t5_addr_no_inc", reg_addr, 8'h30);
        chk_eq("t5_wdata_kept", reg_wdata, 16'h5555);
        write_word_txn(8'h31, 16'hBEEF);
        chk_eq("t5_addr_inc", reg_addr, 8'h32);

        // Reset while the block pulls ACK low
        i2c_start();
        send_bits(8'hBA, 8);
        sda_drv_low = 1'b0;
        wait_clk(5);
        chk_eq("t6_ack_driven", sda_bus, 0);
        #3;
        iRST_N = 1'b0;
        #1;
        chk_eq("t6_sda_async_release", sda_bus, 1);
        chk_eq("t6_addr_rst", reg_addr, 8'h00);
        chk_eq("t6_wdata_rst", reg_wdata, 16'h0000);
        chk_eq("t6_busy_rst", busy, 0);
        chk_eq("t6_wr_rst", reg_wr, 0);
        chk_eq("t6_rd_rst", reg_rd, 0);
        wait_clk(2);
        scl = 1'b1;
        wait_clk(3);
        iRST_N = 1'b1;
        wait_clk(5);
        write_word_txn(8'h05, 16'h0102);
        chk_eq("t6_addr_after", reg_addr, 8'h06);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
